// File: rtl/lru_ctrl_pkg.sv
// Shared definitions for the 2-way LRU replacement controller.
// Holds the geometry constants, the FSM state encoding, the meaning of an
// LRU bit and the layout of the latched lookup request.
package lru_ctrl_pkg;

  // Geometry: one LRU bit per set.
  localparam int unsigned NUM_SETS = 256;
  localparam int unsigned IDX_W    = 8;
  // Flush counter carries one extra bit so the sweep end is unambiguous.
  localparam int unsigned CNT_W    = IDX_W + 1;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RESP  = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  // Way identifiers.
  localparam logic WAY0 = 1'b0;
  localparam logic WAY1 = 1'b1;

  // LRU bit value meaning "way 0 is least recently used"; also the flush value.
  localparam logic LRU_BIT_WAY0_LRU = 1'b0;

  // Request captured from the cache FSM when a lookup is accepted.
  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic             hit;
    logic             hit_way;
    logic             valid0;
    logic             valid1;
  } lru_req_t;

endpackage

// File: rtl/lru_bit_mux.sv
// NUM_SETS:1 read mux returning the LRU bit of the selected set.
// Ports:
//   i_bits  - full LRU storage vector
//   i_index - set index (driven from the latched request)
//   o_bit   - LRU bit of set i_index
module lru_bit_mux
  import lru_ctrl_pkg::*;
(
  input  logic [NUM_SETS-1:0] i_bits,
  input  logic [IDX_W-1:0]    i_index,
  output logic                o_bit
);

  assign o_bit = i_bits[i_index];

endmodule

// File: rtl/lru_ctrl.sv
// LRU replacement-state controller for a 2-way set-associative cache.
// Owns one LRU bit per set, answers one victim/update request at a time and
// sequences a full LRU flush through its single write port.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   req, index   - lookup request and its set index (sampled when ready=1)
//   hit, hit_way - tag hit indication and hitting way
//   valid0/1     - valid bits of way 0 / way 1 at index
//   flush        - start LRU flush (sampled when ready=1, wins over req)
//   ready        - idle, accepting req/flush
//   done         - one-cycle pulse, victim_way valid
//   victim_way   - way to replace (miss) or way that hit (hit)
//   busy         - flush sweep in progress
module lru_ctrl
  import lru_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [IDX_W-1:0] index,
  input  logic             hit,
  input  logic             hit_way,
  input  logic             valid0,
  input  logic             valid1,
  input  logic             flush,
  output logic             ready,
  output logic             done,
  output logic             victim_way,
  output logic             busy
);

  state_t              r_state;
  lru_req_t            r_req;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_SETS-1:0] r_lru;
  logic                r_ready;
  logic                r_done;
  logic                r_busy;
  logic                r_victim_q;

  logic                w_lru_bit;
  logic                w_victim;
  logic                w_wr_en;
  logic [IDX_W-1:0]    w_wr_addr;
  logic                w_wr_data;
  logic [NUM_SETS-1:0] w_wr_onehot;
  logic                w_flush_last;

  // LRU bit of the latched set.
  lru_bit_mux u_lru_bit_mux (
    .i_bits  (r_lru),
    .i_index (r_req.index),
    .o_bit   (w_lru_bit)
  );

  // Victim selection from the latched request only.
  always_comb begin
    w_victim = WAY0;
    if (r_req.hit) begin
      w_victim = r_req.hit_way;
    end else if (!r_req.valid0) begin
      w_victim = WAY0;
    end else if (!r_req.valid1) begin
      w_victim = WAY1;
    end else begin
      w_victim = (w_lru_bit == LRU_BIT_WAY0_LRU) ? WAY0 : WAY1;
    end
  end

  assign w_flush_last = (r_cnt == CNT_W'(NUM_SETS - 1));

  // Single write port: RESP makes the used way MRU, FLUSH clears one set.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = '0;
    w_wr_data = LRU_BIT_WAY0_LRU;
    case (r_state)
      ST_RESP: begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_req.index;
        w_wr_data = ~w_victim;
      end
      ST_FLUSH: begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_cnt[IDX_W-1:0];
        w_wr_data = LRU_BIT_WAY0_LRU;
      end
      default: begin
        w_wr_en = 1'b0;
      end
    endcase
  end

  assign w_wr_onehot = w_wr_en ? (NUM_SETS'(1) << w_wr_addr) : '0;

  // LRU storage; reset clears every set, which also drops any pending update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lru <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_SETS); i++) begin
        if (w_wr_onehot[i]) begin
          r_lru[i] <= w_wr_data;
        end
      end
    end
  end

  // Controller FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_req      <= '0;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_victim_q <= WAY0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (flush) begin
            r_state <= ST_FLUSH;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end else if (req) begin
            r_req.index   <= index;
            r_req.hit     <= hit;
            r_req.hit_way <= hit_way;
            r_req.valid0  <= valid0;
            r_req.valid1  <= valid1;
            r_state       <= ST_RESP;
            r_ready       <= 1'b0;
            r_done        <= 1'b1;
          end
        end
        ST_RESP: begin
          r_state    <= ST_IDLE;
          r_ready    <= 1'b1;
          r_done     <= 1'b0;
          r_victim_q <= w_victim;
        end
        ST_FLUSH: begin
          if (w_flush_last) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ready      = r_ready;
  assign done       = r_done;
  assign busy       = r_busy;
  // Live victim while responding, otherwise hold the last one reported.
  assign victim_way = r_done ? w_victim : r_victim_q;

endmodule

// File: tb/tb_lru_ctrl.sv
// Self-checking bench for lru_ctrl: directed scenarios plus randomized
// requests/flushes checked against a per-set LRU array model.
module tb_lru_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [7:0] index;
  logic       hit;
  logic       hit_way;
  logic       valid0;
  logic       valid1;
  logic       flush;
  logic       ready;
  logic       done;
  logic       victim_way;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: lru_m[s]=0 -> way 0 is LRU in set s.
  bit lru_m [256];

  always #5 clk = ~clk;

  lru_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .index      (index),
    .hit        (hit),
    .hit_way    (hit_way),
    .valid0     (valid0),
    .valid1     (valid1),
    .flush      (flush),
    .ready      (ready),
    .done       (done),
    .victim_way (victim_way),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_victim(input logic [7:0] s, input bit h, input bit hw,
                                    input bit v0, input bit v1);
    if (h) return hw;
    if (!v0) return 1'b0;
    if (!v1) return 1'b1;
    return lru_m[s];
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 256; s++) lru_m[s] = 1'b0;
  endfunction

  task automatic idle_inputs();
    req = 1'b0; flush = 1'b0; index = '0;
    hit = 1'b0; hit_way = 1'b0; valid0 = 1'b0; valid1 = 1'b0;
  endtask

  // One full lookup from IDLE, checking response and return to IDLE.
  task automatic do_req(input logic [7:0] s, input bit h, input bit hw, input bit v0, input bit v1);
    bit exp_v;
    @(negedge clk);
    chk("ready_idle", 32'(ready), 32'd1);
    req = 1'b1; index = s; hit = h; hit_way = hw; valid0 = v0; valid1 = v1;
    @(posedge clk); #1;
    idle_inputs();
    exp_v = ref_victim(s, h, hw, v0, v1);
    chk("done_resp", 32'(done), 32'd1);
    chk("victim", 32'(victim_way), 32'(exp_v));
    chk("ready_resp", 32'(ready), 32'd0);
    lru_m[s] = ~exp_v;
    @(posedge clk); #1;
    chk("done_off", 32'(done), 32'd0);
    chk("ready_back", 32'(ready), 32'd1);
    chk("victim_hold", 32'(victim_way), 32'(exp_v));
  endtask

  // Flush from IDLE, optionally with a simultaneous req that must be dropped.
  task automatic do_flush(input bit with_req);
    int nbusy;
    int ndone;
    int guard;
    @(negedge clk);
    chk("ready_pre_flush", 32'(ready), 32'd1);
    flush = 1'b1; req = with_req; index = 8'($urandom);
    valid0 = 1'b1; valid1 = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    nbusy = 0; ndone = 0; guard = 0;
    while (!ready && guard < 300) begin
      if (busy) nbusy++;
      if (done) ndone++;
      @(posedge clk); #1;
      guard++;
    end
    chk("flush_busy_cycles", 32'(nbusy), 32'd256);
    chk("flush_ready_cycle", 32'(guard), 32'd256);
    chk("flush_no_done", 32'(ndone), 32'd0);
    chk("flush_busy_end", 32'(busy), 32'd0);
    model_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit exp_v;
    int ndone;
    model_clear();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_victim", 32'(victim_way), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Victim selection rules on set 5 and set 255.
    do_req(8'h05, 0, 0, 0, 0);
    do_req(8'h05, 0, 0, 1, 0);
    do_req(8'h05, 0, 0, 1, 1);
    do_req(8'hFF, 1, 1, 1, 1);
    do_req(8'hFF, 0, 0, 1, 1);

    // Set a few bits, then flush with a concurrent req.
    do_req(8'h10, 0, 0, 0, 0);
    do_req(8'h80, 1, 0, 1, 1);
    do_req(8'hFE, 0, 0, 1, 1);
    do_flush(1'b1);
    for (int s = 0; s < 256; s += 17) do_req(8'(s), 0, 0, 1, 1);
    do_req(8'h10, 0, 0, 1, 1);
    do_req(8'h80, 0, 0, 1, 1);

    // Reset in the middle of a flush; high sets must still be cleared.
    do_req(8'hF0, 0, 0, 0, 0);
    do_req(8'hC3, 0, 0, 0, 0);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int k = 1; k < 100; k++) begin
      @(posedge clk); #1;
    end
    chk("busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstf_ready", 32'(ready), 32'd1);
    chk("rstf_busy", 32'(busy), 32'd0);
    chk("rstf_done", 32'(done), 32'd0);
    model_clear();
    do_req(8'hF0, 0, 0, 1, 1);
    do_req(8'hC3, 0, 0, 1, 1);

    // Reset during RESP; the pending update must not land.
    do_req(8'h34, 0, 0, 0, 0);
    @(negedge clk);
    req = 1'b1; index = 8'h33; hit = 1'b1; hit_way = 1'b0; valid0 = 1'b1; valid1 = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    chk("rstr_done_pre", 32'(done), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstr_ready", 32'(ready), 32'd1);
    chk("rstr_done", 32'(done), 32'd0);
    chk("rstr_busy", 32'(busy), 32'd0);
    chk("rstr_victim", 32'(victim_way), 32'd0);
    model_clear();
    do_req(8'h33, 0, 0, 1, 1);
    do_req(8'h34, 0, 0, 1, 1);

    // req held high for 10 cycles: accepted every other edge.
    @(negedge clk);
    req = 1'b1; index = 8'h40; hit = 1'b0; valid0 = 1'b1; valid1 = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      chk("held_ready", 32'(ready), 32'((k % 2) == 0));
      chk("held_done", 32'(done), 32'((k % 2) == 1));
      if (done) begin
        ndone++;
        exp_v = ref_victim(8'h40, 0, 0, 1, 1);
        chk("held_victim", 32'(victim_way), 32'(exp_v));
        lru_m[8'h40] = ~exp_v;
      end
    end
    idle_inputs();
    @(posedge clk); #1;
    chk("held_done_count", 32'(ndone), 32'd5);
    do_req(8'h40, 0, 0, 1, 1);

    // Randomized traffic on a small set range to force reuse.
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 24) == 0) begin
        do_flush(1'($urandom));
      end else begin
        do_req(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7)),
               1'($urandom), 1'($urandom),
               ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lru_ctrl.md
# lru_ctrl

Replacement-state controller for the 2-way set-associative cache. It owns the 256 per-set LRU bits and answers one victim/update request at a time from the cache control FSM. It also sequences a 256-cycle LRU flush through its single write port. It sits beside the tag/data arrays and is driven directly by the cache FSM.

## Interface
Parameters:
- NUM_SETS, 256, number of sets (one LRU bit each)
- IDX_W, 8, index width, log2(NUM_SETS)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  1  lookup request; sampled only when ready=1
- index  in  IDX_W  set index of the request
- hit  in  1  1 = tag hit on this access, 0 = miss (fill pending)
- hit_way  in  1  way that hit; ignored when hit=0
- valid0  in  1  valid bit of way 0 at index
- valid1  in  1  valid bit of way 1 at index
- flush  in  1  start LRU flush; sampled only when ready=1
- ready  out  1  controller idle, will accept req/flush this cycle
- done  out  1  one-cycle pulse, victim_way valid
- victim_way  out  1  way to replace (miss) or way that hit (hit)
- busy  out  1  flush sweep in progress

## Operation
- LRU bit semantics: bit[i]=0 → way 0 is LRU at set i; bit[i]=1 → way 1 is LRU.
- States: IDLE, RESP, FLUSH. The reset state is IDLE.
- IDLE: ready=1. If flush=1, go to FLUSH with cnt=0. flush has priority over a simultaneous req, and that req is dropped. Else if req=1, latch index, hit, hit_way, valid0 and valid1, then go to RESP. Else stay in IDLE.
- RESP: ready=0, done=1. victim_way is selected as follows:
  - hit=1 → victim_way=hit_way.
  - miss with valid0=0 → victim_way=0.
  - miss with valid0=1 and valid1=0 → victim_way=1.
  - miss with both ways valid → victim_way=bit[index].
- RESP write-back: at the end of RESP, bit[index] <= ~victim_way, so the accessed or filled way becomes MRU. Next state is IDLE.
- FLUSH: busy=1, ready=0. bit[cnt] <= 0 each cycle and cnt increments. After writing cnt=NUM_SETS-1, go to IDLE. cnt is IDX_W+1 bits, so there is no wrap ambiguity. req and flush are ignored while in FLUSH.
- Single write port: at most one LRU bit changes per cycle, except during reset.
- Reset (any state, including mid-flush or in RESP): all 256 bits cleared to 0, state=IDLE, cnt=0, latched request cleared. A pending RESP update is discarded.
- Reset values of outputs, visible the cycle after a reset edge: ready=1, done=0, victim_way=0, busy=0.

## Timing
- Request accepted on edge N (req=1, ready=1). done=1 and victim_way are valid during cycle N+1. The LRU write commits on edge N+2, and ready=1 again in cycle N+2.
- Throughput: one request per 2 cycles. A back-to-back req held high is accepted on every other edge.
- A request to the same index immediately after RESP reads the updated bit; no forwarding is needed.
- done and victim_way are registered/state-decoded with no combinational path from inputs. victim_way holds its last value when done=0.
- Flush accepted on edge N. busy=1 in cycles N+1 through N+256. ready=1 in cycle N+257.

## Structure
- Shared package lru_ctrl_pkg holds:
  - state encoding constants (IDLE=2'b00, RESP=2'b01, FLUSH=2'b10);
  - NUM_SETS and IDX_W;
  - the polarity constant for LRU bit meaning.
- Sub-module lru_bit_mux: combinational NUM_SETS:1 select of bit[index_q] feeding the victim logic. Its index comes from the latched request register.
- The top level contains the FSM, flush counter, request latch, and the 256-bit storage with its one-hot write decode.

## Test plan
- Reset, then req index=0x05, miss, valid0=0, valid1=0 → done next cycle with victim_way=0; then bit[5]=1.
- Repeat index=0x05 miss, valid0=1, valid1=0 → victim_way=1, bit[5]=0. Then miss with both valid → victim_way=0, bit[5]=1.
- Hit index=0xFF with hit_way=1 → victim_way=1, bit[255]=0. Then miss with both valid at 0xFF → victim_way=0.
- Set several bits, assert flush and req in the same cycle → req dropped, busy high exactly 256 cycles, ready returns at cycle 257, every bit reads 0 (misses with both valid return victim_way=0).
- Assert rst at flush cycle 100 and separately during RESP → next cycle ready=1, busy=0, done=0, all bits 0, no stale update written.
- Hold req=1 continuously over 10 cycles → exactly 5 done pulses, each one cycle wide, ready alternating 1/0.
